// File: rtl/ccd_acq_ctrl.sv
// ---------------------------------------------------------------------------
// ccd_acq_ctrl
// Acquisition sequencer for the TCD1209D / AD9945 capture chain.
//
// A host start configures the AFE, arms the trigger path and then counts
// frames until done. It also handles stop and timeout. Integration count and
// VGA gain are shadowed here and only change at frame boundaries.
//
// Ports
//   sys_clk, rst_n    system clock, asynchronous active-low reset
//   start, stop       single-cycle host commands
//   frame_num         frames to capture (0 = continuous)
//   trig_mode_in      1 = external trigger, 0 = internal free-run
//   ext_trig_in       asynchronous external trigger
//   exp_cnt_in        requested integration count
//   gain_in           requested VGA gain
//   frame_sof/eof     frame start / end strobes from the capture path
//   triggerMode       latched trigger mode to the driver
//   extTrigger        TRIG_PW-wide trigger pulse to the driver
//   f_cnt, VGA_Gain   shadowed integration count / gain
//   cfg_en            one-cycle AFE configuration request
//   busy              high whenever not IDLE
//   frames_done       frames completed since start (saturating)
//   timeout_err       sticky timeout flag, cleared by start
//   state_o           current state encoding
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start
// CFG      | cfg_en high for this single cycle
// CFG_WAIT | waiting CFG_WAIT_CYC cycles for the AFE serial write
// ARM      | internal: pass through; external: wait for a trigger edge
// WAIT_SOF | waiting for frame start (timeout guarded)
// ACQ      | frame in progress, waiting for frame end (timeout guarded)
// ---------------------------------------------------------------------------
module ccd_acq_ctrl #(
    parameter logic [15:0] CFG_WAIT_CYC = 16'd2000,
    parameter logic [7:0]  TRIG_PW      = 8'd4,
    parameter logic [31:0] TIMEOUT_CYC  = 32'd50_000_000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] frame_num,
    input  logic        trig_mode_in,
    input  logic        ext_trig_in,
    input  logic [24:0] exp_cnt_in,
    input  logic [9:0]  gain_in,
    input  logic        frame_sof,
    input  logic        frame_eof,
    output logic        triggerMode,
    output logic        extTrigger,
    output logic [24:0] f_cnt,
    output logic [9:0]  VGA_Gain,
    output logic        cfg_en,
    output logic        busy,
    output logic [15:0] frames_done,
    output logic        timeout_err,
    output logic [2:0]  state_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CFG      = 3'd1;
    localparam logic [2:0] S_CFG_WAIT = 3'd2;
    localparam logic [2:0] S_ARM      = 3'd3;
    localparam logic [2:0] S_WAIT_SOF = 3'd4;
    localparam logic [2:0] S_ACQ      = 3'd5;

    logic [2:0]  r_state;
    logic [31:0] r_tmr;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_sync3;
    logic        r_trig_edge;
    logic        r_ext_trig;
    logic [7:0]  r_pw_cnt;
    logic        r_trig_mode;
    logic [24:0] r_f_cnt;
    logic [9:0]  r_gain;
    logic [15:0] r_fd;
    logic        r_to_err;
    logic        r_stop_pend;

    logic        w_stop_req;
    logic        w_stop_ok;
    logic        w_tmr_tc;
    logic [15:0] w_fd_inc;
    logic        w_last;
    logic        w_fire;

    assign w_stop_req = stop | r_stop_pend;
    // a stop never cuts a trigger pulse short; it waits for the pulse to end
    assign w_stop_ok  = w_stop_req & ~r_ext_trig;
    assign w_tmr_tc   = (r_tmr == 32'd0);
    assign w_fd_inc   = (r_fd == 16'hFFFF) ? 16'hFFFF : (r_fd + 16'd1);
    assign w_last     = (frame_num != 16'd0) && (w_fd_inc == frame_num);
    assign w_fire     = (r_state == S_ARM) & r_trig_mode & r_trig_edge & ~r_ext_trig;

    // Two-flop synchroniser plus a registered edge detect: an edge is seen
    // three cycles after the input change, the pulse starts one cycle later.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_trig_edge <= 1'b0;
        end else begin
            r_sync1     <= ext_trig_in;
            r_sync2     <= r_sync1;
            r_sync3     <= r_sync2;
            r_trig_edge <= r_sync2 & ~r_sync3;
        end
    end

    // Trigger pulse: down-counter runs independently of the FSM once fired.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_trig <= 1'b0;
            r_pw_cnt   <= 8'd0;
        end else if (w_fire) begin
            r_ext_trig <= 1'b1;
            r_pw_cnt   <= TRIG_PW - 8'd1;
        end else if (r_ext_trig) begin
            if (r_pw_cnt == 8'd0) begin
                r_ext_trig <= 1'b0;
            end else begin
                r_pw_cnt <= r_pw_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tmr       <= 32'd0;
            r_trig_mode <= 1'b0;
            r_f_cnt     <= 25'd0;
            r_gain      <= 10'd0;
            r_fd        <= 16'd0;
            r_to_err    <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            if (stop && (r_state != S_IDLE)) begin
                r_stop_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_f_cnt     <= exp_cnt_in;
                        r_gain      <= gain_in;
                        r_trig_mode <= trig_mode_in;
                        r_fd        <= 16'd0;
                        r_to_err    <= 1'b0;
                        r_state     <= S_CFG;
                    end
                end
                S_CFG: begin
                    if (w_stop_ok) begin
                        r_state     <= S_IDLE;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_tmr   <= {16'd0, CFG_WAIT_CYC - 16'd1};
                        r_state <= S_CFG_WAIT;
                    end
                end
                S_CFG_WAIT: begin
                    if (w_stop_ok) begin
                        r_state     <= S_IDLE;
                        r_stop_pend <= 1'b0;
                    end else if (w_tmr_tc) begin
                        r_state <= S_ARM;
                    end else begin
                        r_tmr <= r_tmr - 32'd1;
                    end
                end
                S_ARM: begin
                    if (w_stop_ok) begin
                        r_state     <= S_IDLE;
                        r_stop_pend <= 1'b0;
                    end else if (!r_trig_mode || w_fire) begin
                        r_tmr   <= TIMEOUT_CYC - 32'd1;
                        r_state <= S_WAIT_SOF;
                    end
                end
                S_WAIT_SOF: begin
                    if (w_stop_ok) begin
                        r_state     <= S_IDLE;
                        r_stop_pend <= 1'b0;
                    end else if (frame_sof) begin
                        r_tmr   <= TIMEOUT_CYC - 32'd1;
                        r_state <= S_ACQ;
                    end else if (w_tmr_tc) begin
                        r_to_err    <= 1'b1;
                        r_state     <= S_IDLE;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_tmr <= r_tmr - 32'd1;
                    end
                end
                S_ACQ: begin
                    // eof outranks both a coincident sof and the timeout
                    if (frame_eof) begin
                        r_fd <= w_fd_inc;
                        if (w_stop_req || w_last) begin
                            r_state     <= S_IDLE;
                            r_stop_pend <= 1'b0;
                        end else if (gain_in != r_gain) begin
                            r_gain  <= gain_in;
                            r_f_cnt <= exp_cnt_in;
                            r_state <= S_CFG;
                        end else begin
                            r_f_cnt <= exp_cnt_in;
                            r_state <= S_ARM;
                        end
                    end else if (w_tmr_tc) begin
                        r_to_err    <= 1'b1;
                        r_state     <= S_IDLE;
                        r_stop_pend <= 1'b0;
                    end else begin
                        r_tmr <= r_tmr - 32'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_stop_pend <= 1'b0;
                end
            endcase
        end
    end

    assign triggerMode = r_trig_mode;
    assign extTrigger  = r_ext_trig;
    assign f_cnt       = r_f_cnt;
    assign VGA_Gain    = r_gain;
    assign cfg_en      = (r_state == S_CFG);
    assign busy        = (r_state != S_IDLE);
    assign frames_done = r_fd;
    assign timeout_err = r_to_err;
    assign state_o     = r_state;

endmodule

// File: doc/ccd_acq_ctrl.md
Name: ccd_acq_ctrl

Overview:
- Acquisition sequencer for the TCD1209D/AD9945 capture chain, running on sys_clk.
- On a host start it configures the AFE, arms the trigger path and counts frames until done; it also handles stop and timeout.
- It owns shadow copies of integration count and VGA gain, and applies them only at frame boundaries.
- Drives triggerMode, extTrigger, f_cnt, VGA_Gain and cfg_en of the capture top level.

Parameters:
- CFG_WAIT_CYC, 16'd2000: sys_clk cycles allowed for one AFE serial write after cfg_en.
- TRIG_PW, 8'd4: width of the extTrigger pulse, in sys_clk cycles.
- TIMEOUT_CYC, 32'd50_000_000: maximum cycles in WAIT_SOF or ACQ before abort.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: begin acquisition
- stop  in  1  single-cycle pulse: abort after the current frame
- frame_num  in  16  frames to capture; 0 = continuous
- trig_mode_in  in  1  1 = external trigger, 0 = internal free-run
- ext_trig_in  in  1  asynchronous external trigger input
- exp_cnt_in  in  25  requested integration count
- gain_in  in  10  requested VGA gain
- frame_sof  in  1  single-cycle pulse, sys_clk-synchronous: frame start (tuser)
- frame_eof  in  1  single-cycle pulse, sys_clk-synchronous: frame end (last tlast)
- triggerMode  out  1  to driver
- extTrigger  out  1  to driver; TRIG_PW-wide pulse
- f_cnt  out  25  shadowed integration count
- VGA_Gain  out  10  shadowed gain
- cfg_en  out  1  single-cycle AFE configuration request
- busy  out  1  high in any state except IDLE
- frames_done  out  16  frames completed since start
- timeout_err  out  1  sticky timeout flag; cleared by start
- state_o  out  3  current state encoding

Behaviour:
- Reset values: all outputs 0; f_cnt = 0; VGA_Gain = 0; state IDLE.
- States and encoding: IDLE=0, CFG=1, CFG_WAIT=2, ARM=3, WAIT_SOF=4, ACQ=5.
- IDLE:
  - On start: latch exp_cnt_in into f_cnt, gain_in into VGA_Gain, trig_mode_in into triggerMode.
  - Clear frames_done and timeout_err, then go to CFG.
  - start is ignored in every other state.
- CFG: assert cfg_en for exactly 1 cycle, then go to CFG_WAIT.
- CFG_WAIT: count CFG_WAIT_CYC cycles, then go to ARM.
- ARM:
  - Internal mode: go straight to WAIT_SOF.
  - External mode: wait for a rising edge of synchronised ext_trig_in (2-flop synchroniser plus edge detect, 3-cycle latency).
  - On that edge, drive extTrigger high for TRIG_PW cycles starting the next cycle, and go to WAIT_SOF.
  - Edges arriving while the pulse is active, or in any other state, are dropped.
- WAIT_SOF: on frame_sof, go to ACQ.
- ACQ, on frame_eof:
  - Increment frames_done, saturating at 16'hFFFF.
  - If a stop is pending, or frame_num != 0 and frames_done+1 == frame_num: go to IDLE.
  - Else if gain_in != VGA_Gain: latch gain_in and exp_cnt_in, then go to CFG.
  - Else: latch exp_cnt_in, then go to ARM.
- Parameter changes never take effect mid-frame.
- Stop:
  - A stop pulse in any non-IDLE state sets stop_pend; stop_pend is cleared on entering IDLE.
  - In CFG, CFG_WAIT, ARM or WAIT_SOF, stop goes to IDLE on the next cycle, but only after any active extTrigger pulse completes.
  - In ACQ, stop waits for frame_eof.
- Timeout:
  - The cycle counter resets on entry to WAIT_SOF and to ACQ.
  - On reaching TIMEOUT_CYC: set timeout_err and go to IDLE.
  - In external mode, ARM has no timeout.
- Simultaneous events:
  - frame_sof and frame_eof in the same cycle while in ACQ: eof wins, and the sof is ignored.
  - stop and start in the same cycle while in IDLE: start wins, and stop is ignored.
  - frame_eof on the same cycle as the timeout: eof wins.
- frame_sof/frame_eof outside WAIT_SOF/ACQ are ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0; an extTrigger pulse in progress is truncated.

Test Plan:
- Internal mode, frame_num=3, CFG_WAIT_CYC=10: start -> cfg_en pulses once, 10 cycles later ARM. 3 sof/eof pairs -> frames_done=3, busy falls on the cycle after the 3rd eof.
- External mode, TRIG_PW=4: edge on ext_trig_in in ARM -> extTrigger high 4 cycles, starting 4 cycles after the edge. A second edge 2 cycles later -> no new pulse.
- frame_num=0, gain_in changed from 10'd100 to 10'd200 mid-ACQ: -> VGA_Gain stays 100 until eof, then becomes 200, cfg_en pulses, and capture continues.
- Stop during ACQ in frame 2 of continuous capture -> frames_done=2, IDLE after eof. Stop during CFG_WAIT -> IDLE next cycle, frames_done=0.
- TIMEOUT_CYC=100 with no frame_sof -> timeout_err=1 and IDLE after 100 cycles in WAIT_SOF. A new start clears timeout_err.
- rst_n low during an active extTrigger pulse -> extTrigger, cfg_en, busy and state_o are 0 immediately (asynchronously).
